// File: rtl/tlv_write_sched.sv
// tlv_write_sched: arbitrates init/CPU/AGC code updates into single TLV5638 writes with post-write settling hold-off.
module tlv_write_sched #(
  parameter int          DATA_W      = 12,
  parameter int          MIN_CODE    = 1512,
  parameter int          PRESET_CODE = 1664,
  parameter logic [5:0]  CONF        = 6'b110001,
  parameter int          SETTLE_CYC  = 4096,
  parameter int          BUSY_TO     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              found,
  input  logic [DATA_W-1:0] agc_code,
  input  logic              preset_req,
  input  logic              cpu_req,
  input  logic [DATA_W-1:0] cpu_code,
  output logic              cpu_ack,
  input  logic              dac_busy,
  output logic              dac_start,
  output logic [DATA_W-1:0] dac_data,
  output logic [5:0]        dac_conf,
  output logic [DATA_W-1:0] cur_code,
  output logic              settling,
  output logic [7:0]        drop_cnt
);
  localparam int CW = $clog2((SETTLE_CYC > BUSY_TO ? SETTLE_CYC : BUSY_TO) + 1);
  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, DONE, SETTLE} state_t;
  state_t            state_q, state_d;
  logic              found_q;
  logic              init_pend_q, init_pend_d, cpu_pend_q, cpu_pend_d, agc_pend_q, agc_pend_d;
  logic [DATA_W-1:0] cpu_val_q, cpu_val_d, agc_val_q, agc_val_d;
  logic [DATA_W-1:0] dac_data_q, dac_data_d, cur_code_q, cur_code_d;
  logic              grant_cpu_q, grant_cpu_d, dac_start_q, cpu_ack_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        drop_q, drop_d;
  logic              edge_det, any_pend, accept;
  logic [DATA_W-1:0] clamped;
  always_comb begin
    edge_det   = found_q & ~found;
    any_pend   = init_pend_q | cpu_pend_q | agc_pend_q;
    // an edge is only taken when IDLE has nothing to grant this cycle
    accept     = edge_det && state_q == IDLE && !any_pend;
    clamped    = preset_req ? DATA_W'(PRESET_CODE)
               : (agc_code < DATA_W'(MIN_CODE) ? DATA_W'(MIN_CODE) : agc_code);
    state_d     = state_q;
    init_pend_d = init_pend_q;
    cpu_pend_d  = cpu_pend_q;
    agc_pend_d  = agc_pend_q;
    cpu_val_d   = cpu_val_q;
    agc_val_d   = agc_val_q;
    dac_data_d  = dac_data_q;
    grant_cpu_d = grant_cpu_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: if (any_pend) begin
        state_d     = START;
        grant_cpu_d = !init_pend_q && cpu_pend_q;
        dac_data_d  = init_pend_q ? DATA_W'(PRESET_CODE) : cpu_pend_q ? cpu_val_q : agc_val_q;
        init_pend_d = 1'b0;
        cpu_pend_d  = init_pend_q ? cpu_pend_q : 1'b0;
        agc_pend_d  = (init_pend_q || cpu_pend_q) ? agc_pend_q : 1'b0;
      end
      START: begin
        state_d = WAIT_HI;
        cnt_d   = '0;
      end
      WAIT_HI: begin
        state_d = dac_busy ? WAIT_LO : (cnt_q == CW'(BUSY_TO - 1) ? DONE : WAIT_HI);
        cnt_d   = cnt_q + CW'(1);
      end
      WAIT_LO: state_d = dac_busy ? WAIT_LO : DONE;
      DONE: begin
        state_d = SETTLE;
        cnt_d   = CW'(SETTLE_CYC - 1);
      end
      SETTLE: begin
        state_d = cnt_q == '0 ? IDLE : SETTLE;
        cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (cpu_req) begin
      cpu_pend_d = 1'b1;
      cpu_val_d  = cpu_code;
    end
    if (accept) begin
      agc_pend_d = 1'b1;
      agc_val_d  = clamped;
    end
    drop_d     = (edge_det && !accept && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    cur_code_d = state_d == DONE ? dac_data_q : cur_code_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      found_q     <= 1'b0;
      init_pend_q <= 1'b1;
      cpu_pend_q  <= 1'b0;
      agc_pend_q  <= 1'b0;
      cpu_val_q   <= '0;
      agc_val_q   <= '0;
      dac_data_q  <= DATA_W'(PRESET_CODE);
      cur_code_q  <= DATA_W'(PRESET_CODE);
      grant_cpu_q <= 1'b0;
      dac_start_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cnt_q       <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      found_q     <= found;
      init_pend_q <= init_pend_d;
      cpu_pend_q  <= cpu_pend_d;
      agc_pend_q  <= agc_pend_d;
      cpu_val_q   <= cpu_val_d;
      agc_val_q   <= agc_val_d;
      dac_data_q  <= dac_data_d;
      cur_code_q  <= cur_code_d;
      grant_cpu_q <= grant_cpu_d;
      dac_start_q <= state_q == START;
      cpu_ack_q   <= state_d == DONE && grant_cpu_q;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
    end
  end
  assign dac_start = dac_start_q;
  assign cpu_ack   = cpu_ack_q;
  assign dac_data  = dac_data_q;
  assign dac_conf  = CONF;
  assign cur_code  = cur_code_q;
  assign settling  = state_q == SETTLE;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_tlv_write_sched.sv
// tb_tlv_write_sched: scoreboard bench; stimulus pushes expected writes, a negedge monitor checks each DAC write.
module tb_tlv_write_sched;
  logic        clk = 0, rst = 1, found = 0, preset_req = 0, cpu_req = 0, dac_busy = 0;
  logic [11:0] agc_code = 0, cpu_code = 0;
  logic        cpu_ack, dac_start, settling;
  logic [11:0] dac_data, cur_code;
  logic [5:0]  dac_conf;
  logic [7:0]  drop_cnt;
  typedef struct {int code; bit cpu; int dly;} exp_t;
  exp_t q[$];
  exp_t cur;
  int n_chk = 0, n_pass = 0, n_ack = 0, busy_len = 20, bcnt = 0;
  int cyc = 0, t_start = 0, scnt = 0;
  bit inflight = 0, prev_ack = 0;

  tlv_write_sched dut (
    .clk(clk), .rst(rst), .found(found), .agc_code(agc_code), .preset_req(preset_req),
    .cpu_req(cpu_req), .cpu_code(cpu_code), .cpu_ack(cpu_ack), .dac_busy(dac_busy),
    .dac_start(dac_start), .dac_data(dac_data), .dac_conf(dac_conf), .cur_code(cur_code),
    .settling(settling), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // serializer model: busy for busy_len cycles after each start
  initial forever begin
    @(negedge clk);
    if (dac_start) bcnt = busy_len;
    else if (bcnt > 0) bcnt--;
    dac_busy = bcnt > 0;
  end

  // monitor: pop on every dac_start, check completion and settle window
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      inflight = 0;
      scnt = 0;
      prev_ack = 0;
    end else begin
      if (cpu_ack) n_ack++;
      if (dac_start) begin
        if (q.size() == 0) chk("unexpected_dac_start", 1, 0);
        else begin
          cur = q.pop_front();
          chk("dac_data", int'(dac_data), cur.code);
          inflight = 1;
          t_start = cyc;
        end
      end
      if (settling) begin
        if (scnt == 0 && inflight) begin
          chk("done_delay", cyc - 1 - t_start, cur.dly);
          chk("cur_code", int'(cur_code), cur.code);
          chk("cpu_ack_at_done", int'(prev_ack), int'(cur.cpu));
        end
        scnt++;
      end else if (scnt != 0) begin
        chk("settle_len", scnt, 4096);
        scnt = 0;
        inflight = 0;
      end
      prev_ack = cpu_ack;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input int code, input bit c, input int dly);
    exp_t e;
    e.code = code; e.cpu = c; e.dly = dly;
    q.push_back(e);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      ok = q.size() == 0 && !inflight;
    end
    chk("wait_done", int'(ok), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic fedge(input int code, input bit pre);
    @(negedge clk);
    found = 1; agc_code = 12'(code); preset_req = pre;
    @(negedge clk);
    found = 0;
  endtask

  task automatic cpu_wr(input int code);
    @(negedge clk);
    cpu_req = 1; cpu_code = 12'(code);
    @(negedge clk);
    cpu_req = 0;
  endtask

  task automatic check_reset_vals();
    chk("rst_dac_start", int'(dac_start), 0);
    chk("rst_cpu_ack", int'(cpu_ack), 0);
    chk("rst_settling", int'(settling), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    chk("rst_dac_data", int'(dac_data), 1664);
    chk("rst_cur_code", int'(cur_code), 1664);
    chk("rst_dac_conf", int'(dac_conf), 6'b110001);
  endtask

  task automatic release_and_check_init();
    push(1664, 0, 21);
    rst = 0;
    @(negedge clk);
    chk("init_start_cyc1", int'(dac_start), 0);
    @(negedge clk);
    chk("init_start_cyc2", int'(dac_start), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals();
    busy_len = 20;
    release_and_check_init();
    wait_done();
    chk("no_ack_init", n_ack, 0);
    busy_len = 3;
    fedge(1400, 0);
    push(1512, 0, 4);
    @(negedge clk);
    @(negedge clk);
    chk("agc_start_n2", int'(dac_start), 0);
    @(negedge clk);
    chk("agc_start_n3", int'(dac_start), 1);
    wait_done();
    fedge(2000, 0);
    push(2000, 0, 4);
    wait_done();
    chk("drop_zero", int'(drop_cnt), 0);
    fedge(3000, 1);
    push(1664, 0, 4);
    wait_done();
    @(negedge clk);
    found = 1; agc_code = 12'd1800; preset_req = 0;
    @(negedge clk);
    found = 0; cpu_req = 1; cpu_code = 12'h0A5;
    push(12'h0A5, 1, 4);
    push(1800, 0, 4);
    @(negedge clk);
    cpu_req = 0;
    wait_done();
    chk("ack_count_after_cpu", n_ack, 1);
    fedge(1700, 0);
    push(1700, 0, 4);
    fedge(1000, 0);
    fedge(2500, 0);
    fedge(1600, 0);
    wait_done();
    chk("drop_three", int'(drop_cnt), 3);
    cpu_wr(12'h123);
    push(12'h123, 1, 4);
    for (int i = 0; i < 300; i++) fedge(1500 + i, 0);
    chk("drop_saturate", int'(drop_cnt), 255);
    wait_done();
    busy_len = 0;
    cpu_wr(12'h3FF);
    push(12'h3FF, 1, 16);
    wait_done();
    busy_len = 20;
    cpu_wr(12'h200);
    push(12'h200, 1, 21);
    repeat (9) @(negedge clk);
    chk("mid_write_busy", int'(dac_busy), 1);
    rst = 1;
    repeat (20) @(negedge clk);
    check_reset_vals();
    release_and_check_init();
    wait_done();
    chk("queue_empty", q.size(), 0);
    chk("ack_total", n_ack, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
